multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Moore FSM sequencer for the multicycle version of the MIPS-subset core.
//  The datapath shares one memory, one ALU and the PC/IR/A/B/ALUOut registers.
//  Decodes Op/Funct once per instruction and steps the datapath through FETCH..writeback.
//  Also provides a retired-instruction counter and an illegal-opcode flag.
// PARAMETERS
//  CNT_W       32  width of InstrRetired counter
//  ADDIU_ZEXT  1   1: ADDIU uses ZeroImm (ALUSrcB=11); 0: uses SignImm (10)
// PORTS
//  CLK           in   1      system clock, all state updates on posedge
//  RST_N         in   1      asynchronous, active-low reset
//  Op            in   6      Instr[31:26] from IR (valid from DECODE onward)
//  Funct         in   6      Instr[5:0] from IR
//  Zero          in   1      ALUResult==0, sampled combinationally in BRANCH
//  IorD          out  1      0: mem addr=PC, 1: mem addr=ALUOut
//  MemWrite      out  1      data-memory write enable
//  IRWrite       out  1      load IR from memory read data
//  RegDst        out  1      0: rt, 1: rd write address
//  MemtoReg      out  1      0: ALUOut, 1: Data reg to WD3
//  RegWrite      out  1      register-file write enable
//  ALUSrcA       out  1      0: PC, 1: A reg
//  ALUSrcB       out  2      00 B reg, 01 const 1, 10 SignImm, 11 ZeroImm
//  ALUControl    out  3      010 add, 110 sub, 000 and, 001 or, 111 slt
//  PCSrc         out  2      00 ALUResult, 01 ALUOut, 10 {PC[31:26],Instr[25:0]}
//  PCEn          out  1      PCWrite | (BrEQ & Zero) | (BrNE & ~Zero)
//  IllegalOp     out  1      one-cycle pulse on undecodable Op/Funct
//  InstrRetired  out  CNT_W  count of completed instructions
// BEHAVIOUR
//  - RST_N low: state=FETCH_WAIT (S_RST); all enables (MemWrite, IRWrite, RegWrite, PCEn) = 0;
//    IllegalOp=0; InstrRetired=0. First FETCH occurs on the first posedge after release.
//  - States and their outputs. Signals not listed are 0; ALUControl defaults to 010.
//    FETCH:   IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, PCSrc=00, PCWrite=1  -> DECODE
//    DECODE:  ALUSrcA=0, ALUSrcB=10 (branch target into ALUOut)              -> by Op
//    MEMADR:  ALUSrcA=1, ALUSrcB=10            -> MEMRD (LW 100011) / MEMWR (SW 101011)
//    MEMRD:   IorD=1                           -> MEMWB
//    MEMWB:   RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH
//    MEMWR:   IorD=1, MemWrite=1               -> FETCH
//    RTYPE:   ALUSrcA=1, ALUSrcB=00, ALUControl from Funct -> ALUWB
//             Funct map: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt
//    ALUWB:   RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH
//    IMMEX:   ALUSrcA=1; ADDI 001000 -> 10/010, ANDI 001100 -> 10/000,
//             ORI 001101 -> 10/001, SLTI 001010 -> 10/111,
//             ADDIU 001001 -> (ADDIU_ZEXT ? 11 : 10)/010                -> IMMWB
//    IMMWB:   RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH
//    BRANCH:  ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01;
//             BrEQ=1 for 000100, BrNE=1 for 000101                    -> FETCH
//    JUMP:    PCSrc=10, PCWrite=1              -> FETCH
//  - Latency in cycles: BEQ/BNE/J 3; R-type/SW/I-ALU 4; LW 5.
//  - Writeback states (MEMWB, MEMWR, ALUWB, IMMWB, BRANCH, JUMP) increment InstrRetired on exit.
//    The counter wraps at 2^CNT_W-1 -> 0 without a flag.
//  - Illegal Op in DECODE, or unknown Funct for Op=000000:
//    IllegalOp=1 for that DECODE cycle, next state FETCH, no register/mem write, not counted.
//  - Op/Funct are only sampled in DECODE and in the per-instruction states, never in FETCH.
//    IR changes during FETCH have no effect.
//  - Reset mid-instruction aborts immediately (async). Enables drop within the same cycle.
//    No partial write completes after RST_N falls.
//  - Outputs are pure functions of state plus Op/Funct/Zero. No X is driven on any output in any state.
// TESTING
//  1. Reset: RST_N=0 for 3 cycles -> enables 0, InstrRetired=0; release -> FETCH has IRWrite=1, PCEn=1.
//  2. LW (Op=100011) -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB in 5 clocks;
//     MemtoReg=1, RegWrite=1 in cycle 5; InstrRetired +1.
//  3. BEQ with Zero=1 -> PCEn=1, PCSrc=01 in cycle 3; with Zero=0 -> PCEn=0.
//     BNE gives the inverse result.
//  4. R-type Funct=101010 -> ALUControl=111 in RTYPE; RegDst=1, RegWrite=1 in ALUWB (cycle 4).
//  5. ADDIU with ADDIU_ZEXT=1 -> ALUSrcB=11; with ADDIU_ZEXT=0 -> 10.
//     Op=111111 -> IllegalOp pulse, back to FETCH, count unchanged.
//  6. RST_N dropped during MEMWR -> MemWrite falls asynchronously; the next instruction starts at FETCH.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Moore FSM sequencer for the multicycle MIPS-subset core.
// Decodes Op/Funct once per instruction, steps the shared datapath from FETCH
// through writeback, counts retired instructions and flags undecodable opcodes.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_op, i_funct         Instr[31:26] / Instr[5:0] from IR
//   i_zero                ALUResult==0, used in BRANCH
//   o_iord .. o_pc_src    datapath mux selects and write enables
//   o_pc_en               PCWrite | (BrEQ & Zero) | (BrNE & ~Zero)
//   o_illegal_op          one-cycle pulse in DECODE on an undecodable Op/Funct
//   o_instr_retired       count of completed instructions (wraps silently)
module multicycle_ctrl #(
    parameter int unsigned CNT_W      = 32,
    parameter bit          ADDIU_ZEXT = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [5:0]       i_op,
    input  logic [5:0]       i_funct,
    input  logic             i_zero,
    output logic             o_iord,
    output logic             o_mem_write,
    output logic             o_ir_write,
    output logic             o_reg_dst,
    output logic             o_mem_to_reg,
    output logic             o_reg_write,
    output logic             o_alu_src_a,
    output logic [1:0]       o_alu_src_b,
    output logic [2:0]       o_alu_control,
    output logic [1:0]       o_pc_src,
    output logic             o_pc_en,
    output logic             o_illegal_op,
    output logic [CNT_W-1:0] o_instr_retired
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_SIMM = 2'b10;
    localparam logic [1:0] SRCB_ZIMM = 2'b11;
    localparam logic [1:0] SRCB_ADDIU = ADDIU_ZEXT ? SRCB_ZIMM : SRCB_SIMM;

    localparam logic [1:0] PC_ALURES = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_RTYPE  = 4'd7,
        S_ALUWB  = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    state_t     r_state;
    state_t     w_next_state;

    logic       w_funct_ok;
    logic [2:0] w_funct_alu;
    logic       w_op_illegal;
    logic       w_pc_write;
    logic       w_br_eq;
    logic       w_br_ne;
    logic       w_retire;
    logic [CNT_W-1:0] r_instr_retired;

    // R-type function decode
    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_alu = ALU_ADD;
        case (i_funct)
            FN_ADD:  w_funct_alu = ALU_ADD;
            FN_SUB:  w_funct_alu = ALU_SUB;
            FN_AND:  w_funct_alu = ALU_AND;
            FN_OR:   w_funct_alu = ALU_OR;
            FN_SLT:  w_funct_alu = ALU_SLT;
            default: w_funct_ok  = 1'b0;
        endcase
    end

    // Opcode legality, including unknown Funct under Op=000000
    always_comb begin
        w_op_illegal = 1'b0;
        case (i_op)
            OP_RTYPE:                              w_op_illegal = ~w_funct_ok;
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J,
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI,
            OP_ORI:                                w_op_illegal = 1'b0;
            default:                               w_op_illegal = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_RST:    w_next_state = S_FETCH;
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (i_op)
                    OP_LW, OP_SW:     w_next_state = S_MEMADR;
                    OP_RTYPE:         w_next_state = w_funct_ok ? S_RTYPE : S_FETCH;
                    OP_ADDI, OP_ADDIU, OP_SLTI,
                    OP_ANDI, OP_ORI:  w_next_state = S_IMMEX;
                    OP_BEQ, OP_BNE:   w_next_state = S_BRANCH;
                    OP_J:             w_next_state = S_JUMP;
                    default:          w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (i_op == OP_LW) begin
                    w_next_state = S_MEMRD;
                end else if (i_op == OP_SW) begin
                    w_next_state = S_MEMWR;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_MEMRD:  w_next_state = S_MEMWB;
            S_RTYPE:  w_next_state = S_ALUWB;
            S_IMMEX:  w_next_state = S_IMMWB;
            default:  w_next_state = S_FETCH;
        endcase
    end

    // Moore outputs, decoded from state plus Op/Funct/Zero
    always_comb begin
        o_iord        = 1'b0;
        o_mem_write   = 1'b0;
        o_ir_write    = 1'b0;
        o_reg_dst     = 1'b0;
        o_mem_to_reg  = 1'b0;
        o_reg_write   = 1'b0;
        o_alu_src_a   = 1'b0;
        o_alu_src_b   = SRCB_REG;
        o_alu_control = ALU_ADD;
        o_pc_src      = PC_ALURES;
        o_illegal_op  = 1'b0;
        w_pc_write    = 1'b0;
        w_br_eq       = 1'b0;
        w_br_ne       = 1'b0;
        w_retire      = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_ir_write  = 1'b1;
                o_alu_src_b = SRCB_ONE;
                w_pc_write  = 1'b1;
            end
            S_DECODE: begin
                o_alu_src_b  = SRCB_SIMM;
                o_illegal_op = w_op_illegal;
            end
            S_MEMADR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_SIMM;
            end
            S_MEMRD: begin
                o_iord = 1'b1;
            end
            S_MEMWB: begin
                o_mem_to_reg = 1'b1;
                o_reg_write  = 1'b1;
                w_retire     = 1'b1;
            end
            S_MEMWR: begin
                o_iord      = 1'b1;
                o_mem_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_RTYPE: begin
                o_alu_src_a   = 1'b1;
                o_alu_control = w_funct_alu;
            end
            S_ALUWB: begin
                o_reg_dst   = 1'b1;
                o_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_IMMEX: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_SIMM;
                case (i_op)
                    OP_ANDI:  o_alu_control = ALU_AND;
                    OP_ORI:   o_alu_control = ALU_OR;
                    OP_SLTI:  o_alu_control = ALU_SLT;
                    OP_ADDIU: o_alu_src_b   = SRCB_ADDIU;
                    default:  o_alu_control = ALU_ADD;
                endcase
            end
            S_IMMWB: begin
                o_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_BRANCH: begin
                o_alu_src_a   = 1'b1;
                o_alu_control = ALU_SUB;
                o_pc_src      = PC_ALUOUT;
                w_br_eq       = (i_op == OP_BEQ);
                w_br_ne       = (i_op == OP_BNE);
                w_retire      = 1'b1;
            end
            S_JUMP: begin
                o_pc_src   = PC_JUMP;
                w_pc_write = 1'b1;
                w_retire   = 1'b1;
            end
            default: begin
                o_illegal_op = 1'b0;
            end
        endcase
        o_pc_en = w_pc_write | (w_br_eq & i_zero) | (w_br_ne & ~i_zero);
    end

    // Retired-instruction counter, bumped as each writeback state exits
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_instr_retired <= '0;
        end else if (w_retire) begin
            r_instr_retired <= r_instr_retired + CNT_W'(1);
        end
    end

    assign o_instr_retired = r_instr_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. A second instance with a 2-bit counter
// and sign-extended ADDIU shares the stimulus to cover the other ADDIU
// encoding and counter wrap.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;

    logic        iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, pc_src;
    logic [2:0]  alu_control;
    logic        pc_en, illegal_op;
    logic [31:0] retired;

    logic        iord_s, mem_write_s, ir_write_s, reg_dst_s, mem_to_reg_s, reg_write_s, alu_src_a_s;
    logic [1:0]  alu_src_b_s, pc_src_s;
    logic [2:0]  alu_control_s;
    logic        pc_en_s, illegal_op_s;
    logic [1:0]  retired_s;

    int checks   = 0;
    int failures = 0;

    multicycle_ctrl #(.CNT_W(32), .ADDIU_ZEXT(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_op(op), .i_funct(funct), .i_zero(zero),
        .o_iord(iord), .o_mem_write(mem_write), .o_ir_write(ir_write),
        .o_reg_dst(reg_dst), .o_mem_to_reg(mem_to_reg), .o_reg_write(reg_write),
        .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b), .o_alu_control(alu_control),
        .o_pc_src(pc_src), .o_pc_en(pc_en), .o_illegal_op(illegal_op),
        .o_instr_retired(retired)
    );

    multicycle_ctrl #(.CNT_W(2), .ADDIU_ZEXT(1'b0)) dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_op(op), .i_funct(funct), .i_zero(zero),
        .o_iord(iord_s), .o_mem_write(mem_write_s), .o_ir_write(ir_write_s),
        .o_reg_dst(reg_dst_s), .o_mem_to_reg(mem_to_reg_s), .o_reg_write(reg_write_s),
        .o_alu_src_a(alu_src_a_s), .o_alu_src_b(alu_src_b_s), .o_alu_control(alu_control_s),
        .o_pc_src(pc_src_s), .o_pc_en(pc_en_s), .o_illegal_op(illegal_op_s),
        .o_instr_retired(retired_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fetch(input string tag, input int exp_ret);
        chk({tag, ".ir_write"}, 32'(ir_write), 32'd1);
        chk({tag, ".pc_en"},    32'(pc_en),    32'd1);
        chk({tag, ".src_b"},    32'(alu_src_b), 32'd1);
        chk({tag, ".retired"},  retired, 32'(exp_ret));
    endtask

    initial begin
        rst_n = 1'b0;
        op    = 6'b000000;
        funct = 6'b100000;
        zero  = 1'b0;

        // Reset held for three cycles
        repeat (3) step();
        chk("rst.ir_write",  32'(ir_write),  32'd0);
        chk("rst.mem_write", 32'(mem_write), 32'd0);
        chk("rst.reg_write", 32'(reg_write), 32'd0);
        chk("rst.pc_en",     32'(pc_en),     32'd0);
        chk("rst.illegal",   32'(illegal_op), 32'd0);
        chk("rst.retired",   retired, 32'd0);
        rst_n = 1'b1;
        step();
        chk_fetch("rst.fetch", 0);

        // LW: FETCH, DECODE, MEMADR, MEMRD, MEMWB
        op = 6'b100011;
        step();
        chk("lw.dec.src_b", 32'(alu_src_b), 32'd2);
        step();
        chk("lw.adr.src_a", 32'(alu_src_a), 32'd1);
        chk("lw.adr.src_b", 32'(alu_src_b), 32'd2);
        step();
        chk("lw.rd.iord", 32'(iord), 32'd1);
        step();
        chk("lw.wb.mem_to_reg", 32'(mem_to_reg), 32'd1);
        chk("lw.wb.reg_write",  32'(reg_write),  32'd1);
        chk("lw.wb.reg_dst",    32'(reg_dst),    32'd0);
        step();
        chk_fetch("lw.next", 1);

        // BEQ/BNE with both Zero values: {op, zero, expected pc_en}
        for (int i = 0; i < 4; i++) begin
            op   = (i < 2) ? 6'b000100 : 6'b000101;
            zero = (i % 2 == 0) ? 1'b1 : 1'b0;
            step();
            step();
            chk($sformatf("br%0d.pc_en", i), 32'(pc_en),
                32'((i == 0 || i == 3) ? 1 : 0));
            chk($sformatf("br%0d.pc_src", i), 32'(pc_src), 32'd1);
            chk($sformatf("br%0d.alu", i), 32'(alu_control), 32'd6);
            step();
            chk($sformatf("br%0d.retired", i), retired, 32'(2 + i));
        end
        zero = 1'b0;

        // R-type SLT
        op = 6'b000000;
        funct = 6'b101010;
        step();
        step();
        chk("slt.alu",   32'(alu_control), 32'd7);
        chk("slt.src_b", 32'(alu_src_b),   32'd0);
        chk("slt.src_a", 32'(alu_src_a),   32'd1);
        step();
        chk("slt.wb.reg_dst",   32'(reg_dst),   32'd1);
        chk("slt.wb.reg_write", 32'(reg_write), 32'd1);
        step();
        chk_fetch("slt.next", 6);

        // ADDIU: zero-extended in dut, sign-extended in dut_s
        op = 6'b001001;
        step();
        step();
        chk("addiu.zext.src_b", 32'(alu_src_b),   32'd3);
        chk("addiu.sext.src_b", 32'(alu_src_b_s), 32'd2);
        chk("addiu.alu",        32'(alu_control), 32'd2);
        step();
        chk("addiu.wb.reg_write", 32'(reg_write), 32'd1);
        chk("addiu.wb.reg_dst",   32'(reg_dst),   32'd0);
        step();
        chk_fetch("addiu.next", 7);
        chk("addiu.retired_s", 32'(retired_s), 32'd3);

        // Illegal opcode, then illegal funct under Op=000000
        op = 6'b111111;
        step();
        chk("ill_op.pulse",     32'(illegal_op), 32'd1);
        chk("ill_op.reg_write", 32'(reg_write),  32'd0);
        step();
        chk("ill_op.clear", 32'(illegal_op), 32'd0);
        chk_fetch("ill_op.next", 7);
        op = 6'b000000;
        funct = 6'b111111;
        step();
        chk("ill_fn.pulse", 32'(illegal_op), 32'd1);
        step();
        chk_fetch("ill_fn.next", 7);

        // Jump; the 2-bit counter wraps 3 -> 0
        op = 6'b000010;
        step();
        chk("j.dec.illegal", 32'(illegal_op), 32'd0);
        step();
        chk("j.pc_src", 32'(pc_src), 32'd2);
        chk("j.pc_en",  32'(pc_en),  32'd1);
        step();
        chk_fetch("j.next", 8);
        chk("j.retired_s_wrap", 32'(retired_s), 32'd0);

        // SW aborted by reset in MEMWR
        op = 6'b101011;
        step();
        step();
        step();
        chk("sw.wr.mem_write", 32'(mem_write), 32'd1);
        chk("sw.wr.iord",      32'(iord),      32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("sw.abort.mem_write", 32'(mem_write), 32'd0);
        chk("sw.abort.iord",      32'(iord),      32'd0);
        chk("sw.abort.retired",   retired, 32'd0);
        step();
        rst_n = 1'b1;
        chk("sw.rst.ir_write", 32'(ir_write), 32'd0);
        step();
        chk_fetch("sw.restart", 0);

        // ANDI after restart
        op = 6'b001100;
        step();
        step();
        chk("andi.alu", 32'(alu_control), 32'd0);
        step();
        step();
        chk_fetch("andi.next", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
